// File: rtl/dcj11_pkg.sv
// Shared DCJ11 bus codes, sequencer state encoding and AIO classification helpers.
package dcj11_pkg;

    localparam logic [3:0] AIO_WORD_WRITE = 4'b0001;
    localparam logic [3:0] AIO_BYTE_WRITE = 4'b0011;
    localparam logic [3:0] AIO_RMW_NOLOCK = 4'b1000;
    localparam logic [3:0] AIO_RMW_LOCK   = 4'b1001;
    localparam logic [3:0] AIO_DATA_READ  = 4'b1010;
    localparam logic [3:0] AIO_IREAD_REQ  = 4'b1011;
    localparam logic [3:0] AIO_IREAD_DEM  = 4'b1100;
    localparam logic [3:0] AIO_IACK       = 4'b1101;
    localparam logic [3:0] AIO_GP_READ    = 4'b1110;
    localparam logic [3:0] AIO_NIO        = 4'b1111;

    localparam logic [1:0] BS_MEM = 2'b00;
    localparam logic [1:0] BS_SYS = 2'b01;
    localparam logic [1:0] BS_EXT = 2'b10;
    localparam logic [1:0] BS_INT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        CPU_HOLD,
        CPU_NXM,
        HOST_ACC
    } seq_state_t;

    function automatic logic is_mem_read(input logic [3:0] aio);
        return aio inside {AIO_RMW_NOLOCK, AIO_RMW_LOCK, AIO_DATA_READ,
                           AIO_IREAD_REQ, AIO_IREAD_DEM};
    endfunction

    function automatic logic is_mem_write(input logic [3:0] aio);
        return aio inside {AIO_WORD_WRITE, AIO_BYTE_WRITE};
    endfunction

endpackage

// File: rtl/dcj11_strobe_sync.sv
// Two-flop synchroniser for N active-low async strobes; reports one selected edge per strobe.
module dcj11_strobe_sync #(
    parameter int             N        = 3,
    parameter logic [N-1:0]   RISE_SEL = '0
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [N-1:0] strb_n_i,
    output logic [N-1:0] edge_o
);

    // Marks when the second sync stage holds a genuinely sampled value after reset.
    logic [1:0] vld_pipe_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) vld_pipe_q <= 2'b00;
        else          vld_pipe_q <= {vld_pipe_q[0], 1'b1};
    end

    for (genvar i = 0; i < N; i++) begin : g_strb
        logic s1_q, s2_q, prev_q, armed_q;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                s1_q    <= 1'b1;
                s2_q    <= 1'b1;
                prev_q  <= 1'b1;
                armed_q <= 1'b0;
            end else begin
                s1_q    <= strb_n_i[i];
                s2_q    <= s1_q;
                prev_q  <= s2_q;
                armed_q <= armed_q | (vld_pipe_q[1] & s2_q);
            end
        end

        // A fall only counts once the strobe was seen high after reset.
        assign edge_o[i] = RISE_SEL[i] ? (~prev_q & s2_q)
                                       : (armed_q & prev_q & ~s2_q);
    end

endmodule

// File: rtl/dcj11_mem_sequencer.sv
// DCJ11 strobe-bus cycle sequencer sharing one SRAM port with the Apple II host.
module dcj11_mem_sequencer
    import dcj11_pkg::*;
#(
    parameter int          AW            = 18,
    parameter logic [21:0] MEM_TOP       = 22'o160000,
    parameter int          MEM_WAIT      = 3,
    parameter int          HOST_MAX_WAIT = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [3:0]    cpu_aio_i,
    input  logic [1:0]    cpu_bs_i,
    input  logic [21:0]   cpu_addr_i,
    input  logic          cpu_ale_n_i,
    input  logic          cpu_strb_n_i,
    input  logic          cpu_sctl_n_i,
    output logic          cpu_cont_n_o,
    output logic          cpu_nxm_o,
    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    output logic          host_ack_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [1:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_src_o
);

    localparam int             WW         = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam int             SW         = $clog2(HOST_MAX_WAIT + 1);
    localparam logic [WW-1:0]  WAIT_LAST  = WW'(MEM_WAIT - 1);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(HOST_MAX_WAIT);

    logic [2:0] edge_w;
    logic       ale_fall, strb_rise, sctl_fall;

    dcj11_strobe_sync #(.N(3), .RISE_SEL(3'b010)) u_sync (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .strb_n_i ({cpu_sctl_n_i, cpu_strb_n_i, cpu_ale_n_i}),
        .edge_o   (edge_w)
    );

    assign ale_fall  = edge_w[0];
    assign strb_rise = edge_w[1];
    assign sctl_fall = edge_w[2];

    logic dec_rd, dec_wr, in_range, dec_mem, dec_nxm;

    assign dec_rd   = is_mem_read(cpu_aio_i);
    assign dec_wr   = is_mem_write(cpu_aio_i);
    assign in_range = cpu_addr_i < MEM_TOP;
    assign dec_mem  = (dec_rd | dec_wr) && cpu_bs_i == BS_MEM && in_range;
    assign dec_nxm  = (dec_rd | dec_wr) &&
                      ((cpu_bs_i == BS_MEM && !in_range) || cpu_bs_i == BS_EXT);

    seq_state_t    state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          pend_q, pend_d;
    logic          nxm_q, nxm_d;
    logic          wr_q, wr_d;
    logic          byte_q, byte_d;
    logic          ready_q, ready_d;
    logic [AW:0]   addr_q, addr_d;
    logic          nio_q, nio_d;
    logic          hblk_q, hblk_d;

    logic cpu_ready, host_ok, last;

    assign cpu_ready = pend_q && !nxm_q && (!wr_q || ready_q);
    assign host_ok   = host_req_i && !hblk_q;
    assign last      = wait_q == WAIT_LAST;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            starve_q <= '0;
            pend_q   <= 1'b0;
            nxm_q    <= 1'b0;
            wr_q     <= 1'b0;
            byte_q   <= 1'b0;
            ready_q  <= 1'b0;
            addr_q   <= '0;
            nio_q    <= 1'b0;
            hblk_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            starve_q <= starve_d;
            pend_q   <= pend_d;
            nxm_q    <= nxm_d;
            wr_q     <= wr_d;
            byte_q   <= byte_d;
            ready_q  <= ready_d;
            addr_q   <= addr_d;
            nio_q    <= nio_d;
            hblk_q   <= hblk_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        starve_d = starve_q;
        pend_d   = pend_q;
        nxm_d    = nxm_q;
        wr_d     = wr_q;
        byte_d   = byte_q;
        ready_d  = ready_q;
        addr_d   = addr_q;
        nio_d    = 1'b0;
        hblk_d   = 1'b0;

        if (sctl_fall && pend_q && wr_q) ready_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                wait_d = '0;
                if (pend_q && nxm_q)                      state_d = CPU_NXM;
                else if (cpu_ready && host_ok)
                    state_d = (starve_q == STARVE_MAX) ? HOST_ACC : CPU_ACC;
                else if (cpu_ready)                       state_d = CPU_ACC;
                else if (host_ok && !pend_q)              state_d = HOST_ACC;
            end
            CPU_ACC: begin
                wait_d = wait_q + WW'(1);
                if (last) begin
                    state_d  = CPU_HOLD;
                    wait_d   = '0;
                    starve_d = !host_req_i ? '0 :
                               (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
                end
            end
            CPU_HOLD, CPU_NXM: begin
                if (strb_rise) begin
                    state_d = IDLE;
                    pend_d  = 1'b0;
                end
            end
            HOST_ACC: begin
                wait_d = wait_q + WW'(1);
                if (last) begin
                    state_d  = IDLE;
                    wait_d   = '0;
                    starve_d = '0;
                    hblk_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh ALE replaces any cycle in flight; only a host access runs on.
        if (ale_fall) begin
            pend_d  = dec_mem | dec_nxm;
            nxm_d   = dec_nxm;
            wr_d    = dec_wr;
            byte_d  = cpu_aio_i == AIO_BYTE_WRITE;
            ready_d = sctl_fall;
            addr_d  = cpu_addr_i[AW:0];
            nio_d   = !(dec_mem | dec_nxm);
            if (state_d != HOST_ACC) begin
                state_d = IDLE;
                wait_d  = '0;
            end
        end
    end

    always_comb begin
        cpu_cont_n_o = ~nio_q;
        cpu_nxm_o    = 1'b0;
        host_ack_o   = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = 2'b00;
        mem_addr_o   = '0;
        mem_src_o    = 1'b0;
        unique case (state_q)
            CPU_ACC: begin
                mem_req_o  = 1'b1;
                mem_we_o   = wr_q;
                mem_be_o   = (wr_q && byte_q) ? (addr_q[0] ? 2'b10 : 2'b01) : 2'b11;
                mem_addr_o = addr_q[AW:1];
            end
            CPU_HOLD: cpu_cont_n_o = 1'b0;
            CPU_NXM: begin
                cpu_cont_n_o = 1'b0;
                cpu_nxm_o    = 1'b1;
            end
            HOST_ACC: begin
                mem_req_o  = 1'b1;
                mem_src_o  = 1'b1;
                mem_we_o   = host_we_i;
                mem_be_o   = 2'b11;
                mem_addr_o = host_addr_i;
                host_ack_o = last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcj11_mem_sequencer.sv
// Directed bench for dcj11_mem_sequencer: CPU read/write, NXM, NIO, host contention, reset abort.
module tb_dcj11_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cpu_aio;
    logic [1:0]  cpu_bs;
    logic [21:0] cpu_addr;
    logic        cpu_ale_n, cpu_strb_n, cpu_sctl_n;
    logic        cpu_cont_n, cpu_nxm;
    logic        host_req, host_we;
    logic [17:0] host_addr;
    logic        host_ack;
    logic        mem_req, mem_we, mem_src;
    logic [1:0]  mem_be;
    logic [17:0] mem_addr;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dcj11_mem_sequencer dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cpu_aio_i(cpu_aio), .cpu_bs_i(cpu_bs), .cpu_addr_i(cpu_addr),
        .cpu_ale_n_i(cpu_ale_n), .cpu_strb_n_i(cpu_strb_n), .cpu_sctl_n_i(cpu_sctl_n),
        .cpu_cont_n_o(cpu_cont_n), .cpu_nxm_o(cpu_nxm),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_ack_o(host_ack),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_addr_o(mem_addr), .mem_src_o(mem_src)
    );

    // contention monitor, sampled on the falling edge
    logic       mon_en = 1'b0;
    logic       prev_cpu = 1'b0, prev_host = 1'b0;
    int         cpu_starts = 0, host_starts = 0, ack_cyc = 0, host_cyc = 0, cpu_at_host = -1;
    logic [17:0] h_addr = '0;
    logic       h_we = 1'b0;
    logic [2:0] starve_after = 3'h7;

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_req && !mem_src && !prev_cpu) begin
                cpu_starts <= cpu_starts + 1;
                if (ack_cyc > 0) starve_after <= dut.starve_q;
            end
            if (mem_req && mem_src && !prev_host) begin
                host_starts <= host_starts + 1;
                cpu_at_host <= cpu_starts;
            end
            if (mem_req && mem_src) begin
                host_cyc <= host_cyc + 1;
                h_addr   <= mem_addr;
                h_we     <= mem_we;
            end
            if (host_ack) ack_cyc <= ack_cyc + 1;
            prev_cpu  <= mem_req && !mem_src;
            prev_host <= mem_req && mem_src;
        end
    end

    int          w_req, w_cont, w_nxm;
    logic [17:0] w_addr;
    logic [1:0]  w_be;
    logic        w_we, w_src;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic window(input int n);
        w_req = 0; w_cont = 0; w_nxm = 0;
        w_addr = '0; w_be = '0; w_we = 1'b0; w_src = 1'b0;
        repeat (n) begin
            tick();
            if (mem_req === 1'b1) begin
                w_req++;
                w_addr = mem_addr; w_be = mem_be; w_we = mem_we; w_src = mem_src;
            end
            if (cpu_cont_n === 1'b0) w_cont++;
            if (cpu_nxm === 1'b1) w_nxm++;
        end
    endtask

    task automatic wait_cont(input logic v, input string tag);
        int k = 0;
        while (cpu_cont_n !== v && k < 60) begin
            tick();
            if (host_ack === 1'b1) host_req = 1'b0;
            k++;
        end
        chk(tag, 32'(cpu_cont_n), 32'(v));
    endtask

    task automatic wait_req(input string tag);
        int k = 0;
        while (mem_req !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk(tag, 32'(mem_req), 32'd1);
    endtask

    task automatic start_cycle(input logic [3:0] aio, input logic [1:0] bs, input logic [21:0] a);
        cpu_aio = aio; cpu_bs = bs; cpu_addr = a;
        cpu_ale_n = 1'b0; cpu_strb_n = 1'b0;
    endtask

    task automatic end_cycle(input string tag);
        cpu_strb_n = 1'b1; cpu_sctl_n = 1'b1;
        wait_cont(1'b1, tag);
        cpu_ale_n = 1'b1;
        repeat (4) tick();
    endtask

    // STRB rises and the next ALE falls together, so the next cycle is pending as HOLD ends.
    task automatic overlap(input logic [21:0] a);
        cpu_ale_n = 1'b1;
        repeat (4) tick();
        cpu_strb_n = 1'b1; cpu_ale_n = 1'b0; cpu_addr = a;
        repeat (2) tick();
        cpu_strb_n = 1'b0;
        wait_cont(1'b1, "ovl_release");
        wait_cont(1'b0, "ovl_hold");
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_aio = 4'b1111; cpu_bs = 2'b00; cpu_addr = '0;
        cpu_ale_n = 1'b1; cpu_strb_n = 1'b1; cpu_sctl_n = 1'b1;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0;
        repeat (3) tick();
        chk("rst_cont_n", 32'(cpu_cont_n), 32'd1);
        chk("rst_nxm",    32'(cpu_nxm),    32'd0);
        chk("rst_ack",    32'(host_ack),   32'd0);
        chk("rst_mem",    {12'd0, mem_req, mem_we, mem_be, mem_addr}, 32'd0);
        chk("rst_src",    32'(mem_src),    32'd0);
        rst_n = 1'b1;
        repeat (5) tick();

        // word read at o1000
        start_cycle(4'b1001, 2'b00, 22'o001000);
        window(12);
        chk("rd_req_cycles", 32'(w_req), 32'd3);
        chk("rd_addr",       32'(w_addr), 32'o400);
        chk("rd_be",         32'(w_be), 32'd3);
        chk("rd_we",         32'(w_we), 32'd0);
        chk("rd_src",        32'(w_src), 32'd0);
        chk("rd_cont_low",   32'(w_cont), 32'd6);
        repeat (5) tick();
        chk("rd_cont_held",  32'(cpu_cont_n), 32'd0);
        end_cycle("rd_release");

        // byte write high byte: held off until SCTL
        start_cycle(4'b0011, 2'b00, 22'o001001);
        window(12);
        chk("bw_no_req", 32'(w_req), 32'd0);
        chk("bw_no_cont", 32'(w_cont), 32'd0);
        cpu_sctl_n = 1'b0;
        window(10);
        chk("bw_req_cycles", 32'(w_req), 32'd3);
        chk("bw_we",   32'(w_we), 32'd1);
        chk("bw_be",   32'(w_be), 32'b10);
        chk("bw_addr", 32'(w_addr), 32'o400);
        chk("bw_hold", 32'(cpu_cont_n), 32'd0);
        end_cycle("bw_release");

        // NXM at the memory top, and any ext-bank read
        start_cycle(4'b1010, 2'b00, 22'o160000);
        window(12);
        chk("nxm_top_req", 32'(w_req), 32'd0);
        chk("nxm_top_flag", 32'(w_nxm), 32'd9);
        chk("nxm_top_cont", 32'(cpu_cont_n), 32'd0);
        end_cycle("nxm_top_release");
        chk("nxm_top_clear", 32'(cpu_nxm), 32'd0);

        start_cycle(4'b1000, 2'b10, 22'o000100);
        window(12);
        chk("nxm_ext_req", 32'(w_req), 32'd0);
        chk("nxm_ext_flag", 32'(w_nxm), 32'd9);
        end_cycle("nxm_ext_release");

        // last word below the top is real memory
        start_cycle(4'b1010, 2'b00, 22'o157776);
        window(12);
        chk("edge_req", 32'(w_req), 32'd3);
        chk("edge_addr", 32'(w_addr), 32'o67777);
        chk("edge_nxm", 32'(w_nxm), 32'd0);
        end_cycle("edge_release");

        // non-memory cycles: one-clock CONT pulse only
        start_cycle(4'b1111, 2'b00, 22'o0);
        window(12);
        chk("nio_req", 32'(w_req), 32'd0);
        chk("nio_cont", 32'(w_cont), 32'd1);
        cpu_strb_n = 1'b1; cpu_ale_n = 1'b1;
        repeat (4) tick();

        start_cycle(4'b1110, 2'b11, 22'o0);
        window(12);
        chk("gp_req", 32'(w_req), 32'd0);
        chk("gp_cont", 32'(w_cont), 32'd1);
        cpu_strb_n = 1'b1; cpu_ale_n = 1'b1;
        repeat (4) tick();

        start_cycle(4'b1010, 2'b01, 22'o001000);
        window(12);
        chk("sys_req", 32'(w_req), 32'd0);
        chk("sys_cont", 32'(w_cont), 32'd1);
        chk("sys_nxm", 32'(w_nxm), 32'd0);
        cpu_strb_n = 1'b1; cpu_ale_n = 1'b1;
        repeat (4) tick();

        // continuous CPU/host contention
        mon_en = 1'b1;
        host_we = 1'b1; host_addr = 18'h25A5A;
        start_cycle(4'b1010, 2'b00, 22'o002000);
        wait_req("ct_first_req");
        host_req = 1'b1;
        wait_cont(1'b0, "ct_first_hold");
        for (int i = 1; i <= 4; i++) overlap(22'o002000 + 22'(2 * i));
        end_cycle("ct_release");
        mon_en = 1'b0;
        chk("ct_cpu_before_host", 32'(cpu_at_host), 32'd4);
        chk("ct_host_grants", 32'(host_starts), 32'd1);
        chk("ct_host_cycles", 32'(host_cyc), 32'd3);
        chk("ct_ack_cycles", 32'(ack_cyc), 32'd1);
        chk("ct_host_addr", 32'(h_addr), 32'h25A5A);
        chk("ct_host_we", 32'(h_we), 32'd1);
        chk("ct_cpu_total", 32'(cpu_starts), 32'd5);
        chk("ct_starve_clear", 32'(starve_after), 32'd0);

        // reset in the middle of a CPU access
        start_cycle(4'b1010, 2'b00, 22'o003000);
        wait_req("rs_req");
        #1 rst_n = 1'b0;
        #1;
        chk("rs_mem_req", 32'(mem_req), 32'd0);
        chk("rs_cont_n", 32'(cpu_cont_n), 32'd1);
        chk("rs_mem_addr", 32'(mem_addr), 32'd0);
        chk("rs_mem_be", 32'(mem_be), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        window(10);
        chk("rs_no_decode_req", 32'(w_req), 32'd0);
        chk("rs_no_decode_cont", 32'(w_cont), 32'd0);
        cpu_ale_n = 1'b1;
        repeat (4) tick();
        cpu_ale_n = 1'b0;
        window(12);
        chk("rs_next_req", 32'(w_req), 32'd3);
        chk("rs_next_addr", 32'(w_addr), 32'o1400);
        chk("rs_next_cont", 32'(w_cont), 32'd6);
        end_cycle("rs_release");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
